// File: rtl/poly_vec_stream_seq.sv
// Sequences a K-vector of polynomials through a coefficient-serial NTT/PWM engine.
// For each active channel: stream operand a (and operand b in dual mode) to the engine,
// then collect N_COEF result coefficients into the packed result vector.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i, dual_i, num_ch_i    operation request (accepted only in IDLE)
//   vec_a_i, vec_b_i             packed operands, held stable by upstream while busy
//   busy_o, done_o, err_o        status (done_o/err_o are 1-cycle pulses)
//   m_*                          coefficient stream to the engine
//   s_*                          result stream from the engine
//   vec_c_o                      packed results
module poly_vec_stream_seq #(
  parameter int unsigned COEF_W = 12,
  parameter int unsigned N_COEF = 256,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned Q      = 3329,
  localparam int unsigned TOT_W  = NUM_CH * N_COEF * COEF_W,
  localparam int unsigned NCH_W  = $clog2(NUM_CH + 1),
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned IDX_W  = (N_COEF > 1) ? $clog2(N_COEF) : 1,
  localparam int unsigned BASE_W = $clog2(TOT_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              dual_i,
  input  logic [NCH_W-1:0]  num_ch_i,
  input  logic [TOT_W-1:0]  vec_a_i,
  input  logic [TOT_W-1:0]  vec_b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [COEF_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic              m_op_o,
  output logic [CH_W-1:0]   m_ch_o,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [COEF_W-1:0] s_data_i,
  input  logic              s_last_i,
  output logic [TOT_W-1:0]  vec_c_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    RECV   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NCH_W-1:0]   num_ch_q, num_ch_d;
  logic               dual_q, dual_d;
  logic               err_q, err_d;
  logic               sticky_q, sticky_d;
  logic [TOT_W-1:0]   vec_c_q, vec_c_d;

  logic [BASE_W-1:0]  base;
  logic [COEF_W-1:0]  coef_raw;
  logic               idx_last;
  logic               ch_last;
  logic               num_legal;
  logic               m_hs;
  logic               s_hs;
  logic               last_mism;

  // Bit offset of the current (channel, coefficient) slot in the packed vectors.
  assign base      = BASE_W'((32'(ch_q) * N_COEF + 32'(idx_q)) * COEF_W);
  assign idx_last  = (idx_q == IDX_W'(N_COEF - 1));
  assign ch_last   = ((NCH_W'(ch_q) + NCH_W'(1)) == num_ch_q);
  assign num_legal = (num_ch_i != '0) && (num_ch_i <= NCH_W'(NUM_CH));

  // Status and stream controls decode directly from the state register.
  assign busy_o    = (state_q == SEND_A) || (state_q == SEND_B) || (state_q == RECV);
  assign done_o    = (state_q == DONE);
  assign err_o     = err_q;
  assign m_valid_o = (state_q == SEND_A) || (state_q == SEND_B);
  assign m_op_o    = (state_q == SEND_B);
  assign m_last_o  = m_valid_o && idx_last;
  assign m_ch_o    = ch_q;
  assign s_ready_o = (state_q == RECV);
  assign vec_c_o   = vec_c_q;

  assign m_hs = m_valid_o && m_ready_i;
  assign s_hs = s_ready_o && s_valid_i;

  // Negative (MSB-set) coefficients are lifted by Q, wrapping at 2^COEF_W.
  assign coef_raw = m_op_o ? vec_b_i[base +: COEF_W] : vec_a_i[base +: COEF_W];
  assign m_data_o = !m_valid_o            ? '0 :
                    coef_raw[COEF_W-1]    ? COEF_W'(coef_raw + COEF_W'(Q)) :
                                            coef_raw;

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    idx_d     = idx_q;
    num_ch_d  = num_ch_q;
    dual_d    = dual_q;
    err_d     = 1'b0;
    sticky_d  = sticky_q;
    vec_c_d   = vec_c_q;
    last_mism = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (num_legal) begin
            state_d  = SEND_A;
            ch_d     = '0;
            idx_d    = '0;
            num_ch_d = num_ch_i;
            dual_d   = dual_i;
            sticky_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      SEND_A, SEND_B: begin
        if (m_hs) begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = (state_q == SEND_A && dual_q) ? SEND_B : RECV;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      RECV: begin
        if (s_hs) begin
          vec_c_d[base +: COEF_W] = s_data_i;
          last_mism = (s_last_i != idx_last);
          sticky_d  = sticky_q || last_mism;
          if (idx_last) begin
            idx_d = '0;
            if (ch_last) begin
              state_d = DONE;
              err_d   = sticky_q || last_mism;
            end else begin
              ch_d    = ch_q + CH_W'(1);
              state_d = SEND_A;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      DONE: begin
        state_d  = IDLE;
        ch_d     = '0;
        sticky_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      idx_q    <= '0;
      num_ch_q <= '0;
      dual_q   <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      vec_c_q  <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      idx_q    <= idx_d;
      num_ch_q <= num_ch_d;
      dual_q   <= dual_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      vec_c_q  <= vec_c_d;
    end
  end

endmodule

// File: tb/tb_poly_vec_stream_seq.sv
// Directed bench for poly_vec_stream_seq: drives an engine model on both streams and
// checks beats, control timing, Q correction, result storage and error/reset behaviour.
module tb_poly_vec_stream_seq;

  localparam int unsigned COEF_W = 12;
  localparam int unsigned N_COEF = 256;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned TOT_W  = NUM_CH * N_COEF * COEF_W;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic              dual_i;
  logic [2:0]        num_ch_i;
  logic [TOT_W-1:0]  vec_a_i;
  logic [TOT_W-1:0]  vec_b_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [11:0]       m_data_o;
  logic              m_last_o;
  logic              m_op_o;
  logic [1:0]        m_ch_o;
  logic              s_valid_i;
  logic              s_ready_o;
  logic [11:0]       s_data_i;
  logic              s_last_i;
  logic [TOT_W-1:0]  vec_c_o;

  int checks = 0;
  int errors = 0;

  logic [11:0] a_m [4][256];
  logic [11:0] b_m [4][256];

  poly_vec_stream_seq dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .dual_i(dual_i),
    .num_ch_i(num_ch_i), .vec_a_i(vec_a_i), .vec_b_i(vec_b_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_last_o(m_last_o), .m_op_o(m_op_o), .m_ch_o(m_ch_o),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .s_last_i(s_last_i), .vec_c_o(vec_c_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] corr(input logic [11:0] x);
    return x[11] ? 12'(x + 12'd3329) : x;
  endfunction

  // Engine result model: NTT echoes a, PWM returns corr(a)+corr(b) mod 2^12.
  function automatic logic [11:0] res(input int c, input int i, input bit dual);
    return dual ? 12'(corr(a_m[c][i]) + corr(b_m[c][i])) : corr(a_m[c][i]);
  endfunction

  function automatic logic [11:0] slot(input logic [TOT_W-1:0] v, input int c, input int i);
    logic [TOT_W-1:0] t;
    t = v >> ((c * 256 + i) * 12);
    return t[11:0];
  endfunction

  task automatic load_vecs();
    logic [TOT_W-1:0] va, vb;
    va = '0;
    vb = '0;
    for (int k = 1023; k >= 0; k--) begin
      va = (va << 12) | TOT_W'(a_m[k / 256][k % 256]);
      vb = (vb << 12) | TOT_W'(b_m[k / 256][k % 256]);
    end
    vec_a_i = va;
    vec_b_i = vb;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rst_busy"},   32'(busy_o), 0);
    chk({tag, "_rst_done"},   32'(done_o), 0);
    chk({tag, "_rst_err"},    32'(err_o), 0);
    chk({tag, "_rst_mvalid"}, 32'(m_valid_o), 0);
    chk({tag, "_rst_mlast"},  32'(m_last_o), 0);
    chk({tag, "_rst_mop"},    32'(m_op_o), 0);
    chk({tag, "_rst_sready"}, 32'(s_ready_o), 0);
    chk({tag, "_rst_mch"},    32'(m_ch_o), 0);
    chk({tag, "_rst_mdata"},  32'(m_data_o), 0);
    chk({tag, "_rst_vecc"},   32'(vec_c_o != '0), 0);
  endtask

  // Runs one operation end-to-end with a cycle-accurate expectation of both streams.
  task automatic run_op(input int nch, input bit dual, input bit rnd, input int bad_idx,
                        input bit abort_op, input string tag);
    int ph, ch, idx, beats, data_err, ctl_err, stall_err, c_err, u_err;
    bit got_done, aborted, prev_stall;
    logic [11:0] prev_data, exp_d;
    logic [TOT_W-1:0] snap;
    ph = 0; ch = 0; idx = 0; beats = 0; data_err = 0; ctl_err = 0; stall_err = 0;
    got_done = 0; aborted = 0; prev_stall = 0; prev_data = '0;
    load_vecs();
    snap = vec_c_o;
    num_ch_i = 3'(nch);
    dual_i   = dual;
    start_i  = 1'b1;
    @(posedge clk_i); #1;
    start_i  = 1'b0;
    chk({tag, "_busy_start"},   32'(busy_o), 1);
    chk({tag, "_mvalid_first"}, 32'(m_valid_o), 1);
    for (int cyc = 0; cyc < 20000 && !got_done && !aborted; cyc++) begin
      if (ph == 3) begin
        got_done  = 1;
        m_ready_i = 1'b0;
        s_valid_i = 1'b0;
        chk({tag, "_done"},      32'(done_o), 1);
        chk({tag, "_busy_done"}, 32'(busy_o), 0);
        chk({tag, "_err_done"},  32'(err_o), (bad_idx >= 0) ? 1 : 0);
        @(posedge clk_i); #1;
        chk({tag, "_done_once"}, 32'(done_o), 0);
        chk({tag, "_err_once"},  32'(err_o), 0);
      end else begin
        m_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        s_valid_i = 1'b1;
        s_data_i  = (ph == 2) ? res(ch, idx, dual) : 12'($urandom);
        s_last_i  = (ph != 2) ? 1'b1 : (bad_idx >= 0) ? (idx == bad_idx) : (idx == 255);
        if (m_valid_o !== (ph < 2) || s_ready_o !== (ph == 2) || busy_o !== 1'b1 ||
            done_o !== 1'b0 || err_o !== 1'b0)
          ctl_err++;
        if (ph < 2) begin
          exp_d = corr(ph == 0 ? a_m[ch][idx] : b_m[ch][idx]);
          if (m_data_o !== exp_d || m_last_o !== (idx == 255) ||
              m_op_o !== (ph == 1) || m_ch_o !== 2'(ch))
            data_err++;
          if (prev_stall && m_data_o !== prev_data) stall_err++;
          prev_stall = !m_ready_i;
          prev_data  = m_data_o;
          if (m_ready_i) begin
            beats++;
            idx++;
            if (idx == 256) begin
              idx = 0;
              ph  = (ph == 0 && dual) ? 1 : 2;
              prev_stall = 0;
            end
          end
        end else begin
          prev_stall = 0;
          if (abort_op && ch == 1 && idx == 10) begin
            rst_i = 1'b1;
            @(posedge clk_i); #1;
            rst_i     = 1'b0;
            s_valid_i = 1'b0;
            aborted   = 1;
            check_reset(tag);
          end else begin
            idx++;
            if (idx == 256) begin
              idx = 0;
              ch++;
              ph = (ch == nch) ? 3 : 0;
            end
          end
        end
        if (!aborted) begin
          @(posedge clk_i); #1;
        end
      end
    end
    if (!aborted) begin
      chk({tag, "_done_seen"}, 32'(got_done), 1);
      chk({tag, "_m_beats"},   32'(beats), 32'(nch * 256 * (dual ? 2 : 1)));
      chk({tag, "_m_stream"},  32'(data_err), 0);
      chk({tag, "_ctl"},       32'(ctl_err), 0);
      chk({tag, "_stall"},     32'(stall_err), 0);
      c_err = 0;
      u_err = 0;
      for (int c = 0; c < 4; c++)
        for (int i = 0; i < 256; i++) begin
          if (c < nch) begin
            if (slot(vec_c_o, c, i) !== res(c, i, dual)) c_err++;
          end else begin
            if (slot(vec_c_o, c, i) !== slot(snap, c, i)) u_err++;
          end
        end
      chk({tag, "_vecc_active"},    32'(c_err), 0);
      chk({tag, "_vecc_untouched"}, 32'(u_err), 0);
    end
  endtask

  task automatic illegal_start(input int nch, input string tag);
    num_ch_i = 3'(nch);
    dual_i   = 1'b0;
    start_i  = 1'b1;
    @(posedge clk_i); #1;
    start_i  = 1'b0;
    chk({tag, "_err"},    32'(err_o), 1);
    chk({tag, "_busy"},   32'(busy_o), 0);
    chk({tag, "_mvalid"}, 32'(m_valid_o), 0);
    @(posedge clk_i); #1;
    chk({tag, "_err_pulse"}, 32'(err_o), 0);
    chk({tag, "_busy2"},     32'(busy_o), 0);
    chk({tag, "_mvalid2"},   32'(m_valid_o), 0);
  endtask

  initial begin
    int nz;
    rst_i = 1'b1; start_i = 1'b0; dual_i = 1'b0; num_ch_i = '0;
    m_ready_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0; s_last_i = 1'b0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 256; i++) begin
        a_m[c][i] = 12'((c * 977 + i * 13 + 5) % 4096);
        b_m[c][i] = 12'((i * 7 + c * 100 + 2304) % 4096);
      end
    vec_a_i = '0;
    vec_b_i = '0;
    @(posedge clk_i); @(posedge clk_i); #1;
    check_reset("reset");
    rst_i = 1'b0;

    // T1: single channel NTT, ramp data, echo engine.
    for (int i = 0; i < 256; i++) a_m[0][i] = 12'(i);
    run_op(1, 1'b0, 1'b0, -1, 1'b0, "t1");

    // T2: Q correction of MSB-set coefficients (4095+3329 mod 4096 = 3328).
    a_m[0][0] = 12'hFFF;
    a_m[0][1] = 12'h7FF;
    a_m[0][2] = 12'h800;
    run_op(1, 1'b0, 1'b0, -1, 1'b0, "t2");
    chk("t2_neg1",  32'(slot(vec_c_o, 0, 0)), 32'h0D00);
    chk("t2_7ff",   32'(slot(vec_c_o, 0, 1)), 32'h07FF);
    chk("t2_800",   32'(slot(vec_c_o, 0, 2)), 32'h0501);

    // T3: three channels, dual operands, random engine backpressure.
    for (int i = 0; i < 256; i++) a_m[0][i] = 12'((i * 29 + 2000) % 4096);
    run_op(3, 1'b1, 1'b1, -1, 1'b0, "t3");
    nz = 0;
    for (int i = 0; i < 256; i++) if (slot(vec_c_o, 3, i) !== 12'h000) nz++;
    chk("t3_ch3_zero", 32'(nz), 0);

    // T4: illegal channel counts.
    illegal_start(0, "t4_n0");
    illegal_start(5, "t4_n5");

    // T5: engine flags last at coefficient 100 instead of 255.
    run_op(1, 1'b0, 1'b0, 100, 1'b0, "t5");

    // T6: reset while receiving channel 1, then a fresh complete operation.
    run_op(2, 1'b0, 1'b0, -1, 1'b1, "t6_abort");
    run_op(2, 1'b1, 1'b0, -1, 1'b0, "t6_fresh");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
